// File: rtl/bp_fe_scan_pkg.sv
// Shared types for the fetch-to-issue scan controller: instruction classes,
// sequencer states and the 69-bit scan result.
package bp_fe_scan_pkg;

  localparam int scan_imm_width_lp = 64;

  localparam logic [6:0] opcode_branch_lp = 7'b1100011;
  localparam logic [6:0] opcode_jalr_lp   = 7'b1100111;
  localparam logic [6:0] opcode_jal_lp    = 7'b1101111;

  typedef enum logic [1:0] {
    e_class_branch = 2'b00,
    e_class_jalr   = 2'b01,
    e_class_jal    = 2'b10,
    e_class_other  = 2'b11
  } instr_class_e;

  typedef enum logic [2:0] {
    e_empty,
    e_hold,
    e_hold_taken,
    e_hold_jalr,
    e_jalr_wait,
    e_jalr_redir
  } scan_state_e;

  // Bit 68 compressed, 67:66 reserved, 65:64 class, 63:0 sign-extended immediate.
  typedef struct packed {
    logic                         compressed;
    logic [1:0]                   rsvd;
    instr_class_e                 iclass;
    logic [scan_imm_width_lp-1:0] imm;
  } scan_s;

endpackage

// File: rtl/bp_fe_scan_ctrl_if.sv
// Fetch, issue, redirect and resolve channels of the scan controller.
// Signal suffixes are relative to the controller (slave side).
interface bp_fe_scan_ctrl_if
  import bp_fe_scan_pkg::*;
#(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32
);

  logic                     fetch_v_i;
  logic [eaddr_width_p-1:0] fetch_pc_i;
  logic [instr_width_p-1:0] fetch_instr_i;
  logic                     fetch_ready_o;

  logic                     issue_v_o;
  logic                     issue_ready_i;
  logic [eaddr_width_p-1:0] issue_pc_o;
  logic [instr_width_p-1:0] issue_instr_o;
  instr_class_e             issue_class_o;
  logic                     issue_pred_taken_o;
  logic                     issue_compressed_o;

  logic                     redirect_v_o;
  logic [eaddr_width_p-1:0] redirect_pc_o;
  logic                     redirect_yumi_i;

  logic                     resolve_v_i;
  logic [eaddr_width_p-1:0] resolve_pc_i;

  modport slave (
    input  fetch_v_i, fetch_pc_i, fetch_instr_i, issue_ready_i,
           redirect_yumi_i, resolve_v_i, resolve_pc_i,
    output fetch_ready_o, issue_v_o, issue_pc_o, issue_instr_o, issue_class_o,
           issue_pred_taken_o, issue_compressed_o, redirect_v_o, redirect_pc_o
  );

  modport master (
    output fetch_v_i, fetch_pc_i, fetch_instr_i, issue_ready_i,
           redirect_yumi_i, resolve_v_i, resolve_pc_i,
    input  fetch_ready_o, issue_v_o, issue_pc_o, issue_instr_o, issue_class_o,
           issue_pred_taken_o, issue_compressed_o, redirect_v_o, redirect_pc_o
  );

endinterface

// File: rtl/bp_fe_scan_ctrl_scan.sv
// Combinational instruction scan: classifies control-flow instructions and
// extracts their sign-extended immediate. Compressed encodings scan as "other".
module bp_fe_scan_ctrl_scan
  import bp_fe_scan_pkg::*;
#(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32
)(
  input  logic [instr_width_p-1:0] instr_i,
  output scan_s                    scan_o
);

  logic [eaddr_width_p-1:0] imm_b;
  logic [eaddr_width_p-1:0] imm_j;
  logic [eaddr_width_p-1:0] imm_i;

  assign imm_b = {{(eaddr_width_p-12){instr_i[31]}}, instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_j = {{(eaddr_width_p-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};
  assign imm_i = {{(eaddr_width_p-12){instr_i[31]}}, instr_i[31:20]};

  always_comb begin
    scan_o            = '0;
    scan_o.iclass     = e_class_other;
    scan_o.compressed = (instr_i[1:0] != 2'b11);
    if (!scan_o.compressed) begin
      case (instr_i[6:0])
        opcode_branch_lp: begin scan_o.iclass = e_class_branch; scan_o.imm = imm_b; end
        opcode_jalr_lp:   begin scan_o.iclass = e_class_jalr;   scan_o.imm = imm_i; end
        opcode_jal_lp:    begin scan_o.iclass = e_class_jal;    scan_o.imm = imm_j; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_scan_ctrl.sv
// Single-entry fetch-to-issue sequencer with static prediction: JAL and backward
// branches redirect fetch at capture; JALR stalls fetch until the backend resolves it.
module bp_fe_scan_ctrl
  import bp_fe_scan_pkg::*;
#(
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32
)(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  bp_fe_scan_ctrl_if.slave      bus
);

  scan_state_e              state_q, state_d, cap_state;
  logic [eaddr_width_p-1:0] pc_q, pc_d, redir_pc_q, redir_pc_d, cap_target;
  logic [instr_width_p-1:0] instr_q, instr_d;
  instr_class_e             class_q, class_d;
  logic                     compressed_q, compressed_d, pred_q, pred_d;
  logic                     issue_done_q, issue_done_d, redir_done_q, redir_done_d;

  scan_s scan_in;
  logic  scan_unused;
  logic  kill, fetch_ready, issue_v, redirect_v;
  logic  capture, issue_fire, redir_fire, cap_pred;

  // The incoming instruction is scanned as it enters the hold register.
  bp_fe_scan_ctrl_scan #(
    .eaddr_width_p(eaddr_width_p),
    .instr_width_p(instr_width_p)
  ) u_scan (
    .instr_i(bus.fetch_instr_i),
    .scan_o (scan_in)
  );

  assign scan_unused = ^scan_in.rsvd;
  assign kill        = reset_i | flush_i;
  assign cap_pred    = (scan_in.iclass == e_class_jal)
                     | ((scan_in.iclass == e_class_branch) & scan_in.imm[scan_imm_width_lp-1]);
  assign cap_target  = bus.fetch_pc_i + scan_in.imm;

  always_comb begin
    if (cap_pred)                           cap_state = e_hold_taken;
    else if (scan_in.iclass == e_class_jalr) cap_state = e_hold_jalr;
    else                                     cap_state = e_hold;
  end

  always_comb begin
    fetch_ready = 1'b0;
    issue_v     = 1'b0;
    redirect_v  = 1'b0;
    case (state_q)
      e_empty:      fetch_ready = 1'b1;
      e_hold:       begin issue_v = 1'b1; fetch_ready = bus.issue_ready_i; end
      e_hold_taken: begin issue_v = ~issue_done_q; redirect_v = ~redir_done_q; end
      e_hold_jalr:  issue_v = 1'b1;
      e_jalr_redir: redirect_v = 1'b1;
      default: ;
    endcase
    if (kill) begin
      fetch_ready = 1'b0;
      issue_v     = 1'b0;
      redirect_v  = 1'b0;
    end
  end

  assign capture    = fetch_ready & bus.fetch_v_i;
  assign issue_fire = issue_v & bus.issue_ready_i;
  assign redir_fire = redirect_v & bus.redirect_yumi_i;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    class_d      = class_q;
    compressed_d = compressed_q;
    pred_d       = pred_q;
    redir_pc_d   = redir_pc_q;
    issue_done_d = issue_done_q;
    redir_done_d = redir_done_q;

    if (capture) begin
      pc_d         = bus.fetch_pc_i;
      instr_d      = bus.fetch_instr_i;
      class_d      = scan_in.iclass;
      compressed_d = scan_in.compressed;
      pred_d       = cap_pred;
      redir_pc_d   = cap_target;
    end

    case (state_q)
      e_empty: if (capture) state_d = cap_state;
      e_hold:  if (issue_fire) state_d = capture ? cap_state : e_empty;
      e_hold_taken: begin
        issue_done_d = issue_done_q | issue_fire;
        redir_done_d = redir_done_q | redir_fire;
        if (issue_done_d && redir_done_d) begin
          state_d      = e_empty;
          issue_done_d = 1'b0;
          redir_done_d = 1'b0;
        end
      end
      e_hold_jalr: if (issue_fire) state_d = e_jalr_wait;
      e_jalr_wait: begin
        if (bus.resolve_v_i) begin
          state_d    = e_jalr_redir;
          redir_pc_d = bus.resolve_pc_i;
        end
      end
      e_jalr_redir: if (redir_fire) state_d = e_empty;
      default: state_d = e_empty;
    endcase

    // A flush drops the entry outright, exactly as a reset would.
    if (kill) begin
      state_d      = e_empty;
      pc_d         = '0;
      instr_d      = '0;
      class_d      = e_class_branch;
      compressed_d = 1'b0;
      pred_d       = 1'b0;
      redir_pc_d   = '0;
      issue_done_d = 1'b0;
      redir_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= e_empty;
      pc_q         <= '0;
      instr_q      <= '0;
      class_q      <= e_class_branch;
      compressed_q <= 1'b0;
      pred_q       <= 1'b0;
      redir_pc_q   <= '0;
      issue_done_q <= 1'b0;
      redir_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      class_q      <= class_d;
      compressed_q <= compressed_d;
      pred_q       <= pred_d;
      redir_pc_q   <= redir_pc_d;
      issue_done_q <= issue_done_d;
      redir_done_q <= redir_done_d;
    end
  end

  assign bus.fetch_ready_o      = fetch_ready;
  assign bus.issue_v_o          = issue_v;
  assign bus.issue_pc_o         = pc_q;
  assign bus.issue_instr_o      = instr_q;
  assign bus.issue_class_o      = class_q;
  assign bus.issue_pred_taken_o = pred_q;
  assign bus.issue_compressed_o = compressed_q;
  assign bus.redirect_v_o       = redirect_v;
  assign bus.redirect_pc_o      = redir_pc_q;

endmodule
